// File: rtl/matrix_key_scanner_pkg.sv
`default_nettype none
// matrix_key_pkg: shared state encoding and column-pattern helpers for matrix_key_scanner.
// Rev 1.0

package matrix_key_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // Helpers take a fixed-width pattern; callers pad unused upper bits with ones.
    localparam int unsigned c_max_cols = 32;
    localparam int unsigned c_idx_w    = 5;

    function automatic logic [1:0] onehot_low_count(input logic [c_max_cols-1:0] col);
        logic [1:0] cnt;
        cnt = 2'd0;
        for (int i = 0; i < c_max_cols; i++) begin
            if (!col[i] && (cnt != 2'd2)) begin
                cnt = cnt + 2'd1;
            end
        end
        return cnt;
    endfunction

    function automatic logic [c_idx_w-1:0] encode_col(input logic [c_max_cols-1:0] col);
        logic [c_idx_w-1:0] idx;
        idx = '0;
        for (int i = c_max_cols - 1; i >= 0; i--) begin
            if (!col[i]) begin
                idx = c_idx_w'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_key_scanner_sync_2ff.sv
`default_nettype none
// sync_2ff: two-flop synchroniser for asynchronous inputs; idles at all ones.
// Rev 1.0

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/matrix_key_scanner.sv
`default_nettype none
// matrix_key_scanner: row-scanning keypad front end with press/release debounce and a valid/ready key event output.
// Rev 1.0

module matrix_key_scanner
    import matrix_key_pkg::*;
#(
    parameter  int NROWS     = 4,
    parameter  int NCOLS     = 4,
    parameter  int SCAN_DIV  = 6000,
    parameter  int SETTLE    = 3,
    parameter  int DB_CYCLES = 60000,
    localparam int KW        = $clog2(NROWS * NCOLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [NROWS-1:0] row,
    input  logic [NCOLS-1:0] col,
    output logic [KW-1:0]    key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_held,
    output logic             multi_key,
    output logic             overrun
);

    localparam int c_rw = $clog2(NROWS);
    localparam int c_cw = $clog2(NCOLS);
    localparam int c_dw = $clog2(SCAN_DIV);
    localparam int c_bw = $clog2(DB_CYCLES);

    state_t            state_q, state_d;
    logic [c_rw-1:0]   row_sel_q, row_sel_d;
    logic [c_dw-1:0]   dwell_q, dwell_d;
    logic [c_bw-1:0]   db_q, db_d;
    logic [c_cw-1:0]   col_idx_q, col_idx_d;
    logic [KW-1:0]     code_q, code_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;
    logic              multi_q, multi_d;
    logic              overrun_q, overrun_d;

    logic [NCOLS-1:0]      col_sync;
    logic [c_max_cols-1:0] w_col_ext;
    logic [1:0]            w_low_cnt;
    logic [c_cw-1:0]       w_col_enc;
    logic [NCOLS-1:0]      w_latched_pat;
    logic                  w_window;
    logic                  w_dwell_tc;
    logic                  w_db_tc;
    logic [c_rw-1:0]       w_row_next;
    logic [KW-1:0]         w_code;
    logic                  w_fire;

    sync_2ff #(
        .WIDTH (NCOLS)
    ) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (col),
        .q_o   (col_sync)
    );

    always_comb begin
        w_col_ext               = '1;
        w_col_ext[NCOLS-1:0]    = col_sync;
        w_latched_pat           = '1;
        w_latched_pat[col_idx_q] = 1'b0;
    end

    assign w_low_cnt  = onehot_low_count(w_col_ext);
    assign w_col_enc  = c_cw'(encode_col(w_col_ext));
    assign w_window   = (dwell_q >= c_dw'(SETTLE));
    assign w_dwell_tc = (dwell_q == c_dw'(SCAN_DIV - 1));
    assign w_db_tc    = (db_q == c_bw'(DB_CYCLES - 1));
    assign w_row_next = (row_sel_q == c_rw'(NROWS - 1)) ? '0 : row_sel_q + c_rw'(1);
    // Row index is frozen outside SCAN, so it doubles as the latched row.
    assign w_code     = KW'(row_sel_q) * KW'(NCOLS) + KW'(col_idx_q);

    always_comb begin
        state_d   = state_q;
        row_sel_d = row_sel_q;
        dwell_d   = dwell_q;
        db_d      = db_q;
        col_idx_d = col_idx_q;
        code_d    = code_q;
        held_d    = held_q;
        multi_d   = multi_q;
        overrun_d = 1'b0;
        w_fire    = 1'b0;
        valid_d   = valid_q & ~key_ready;

        unique case (state_q)
            SCAN: begin
                if (w_window && (w_low_cnt == 2'd1)) begin
                    state_d   = PRESS_DB;
                    col_idx_d = w_col_enc;
                    db_d      = '0;
                end else begin
                    if (w_window && (w_low_cnt == 2'd2)) begin
                        multi_d = 1'b1;
                    end else if (w_window && (w_low_cnt == 2'd0)) begin
                        multi_d = 1'b0;
                    end
                    if (w_dwell_tc) begin
                        dwell_d   = '0;
                        row_sel_d = w_row_next;
                        multi_d   = 1'b0;
                    end else begin
                        dwell_d = dwell_q + c_dw'(1);
                    end
                end
            end

            PRESS_DB: begin
                if (col_sync == w_latched_pat) begin
                    if (w_db_tc) begin
                        state_d = HELD;
                        held_d  = 1'b1;
                        w_fire  = 1'b1;
                    end else begin
                        db_d = db_q + c_bw'(1);
                    end
                end else begin
                    state_d = SCAN;
                    dwell_d = '0;
                end
            end

            HELD: begin
                if (col_sync[col_idx_q]) begin
                    state_d = REL_DB;
                    db_d    = '0;
                end
            end

            REL_DB: begin
                if (!col_sync[col_idx_q]) begin
                    state_d = HELD;
                    db_d    = '0;
                end else if (w_db_tc) begin
                    state_d   = SCAN;
                    held_d    = 1'b0;
                    row_sel_d = w_row_next;
                    dwell_d   = '0;
                end else begin
                    db_d = db_q + c_bw'(1);
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase

        // A new event may replace one that is being consumed this same cycle.
        if (w_fire) begin
            if (!valid_q || key_ready) begin
                code_d  = w_code;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            row_sel_q <= '0;
            dwell_q   <= '0;
            db_q      <= '0;
            col_idx_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            multi_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_sel_q <= row_sel_d;
            dwell_q   <= dwell_d;
            db_q      <= db_d;
            col_idx_q <= col_idx_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            multi_q   <= multi_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        row            = '1;
        row[row_sel_q] = 1'b0;
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign multi_key = multi_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_key_scanner.sv
`default_nettype none
// tb_matrix_key_scanner: self-checking bench with a behavioural switch-matrix model and key-event scoreboard.
// Rev 1.0

module tb_matrix_key_scanner;

    localparam int NR   = 4;
    localparam int NC   = 4;
    localparam int HALF = 167;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_held;
    logic        multi_key;
    logic        overrun;
    logic [15:0] pressed   = '0;

    int checks      = 0;
    int failures    = 0;
    int valid_rises = 0;
    int ovr_cnt     = 0;
    int multi_cnt   = 0;
    logic prev_valid = 1'b0;
    int exp_q[$];

    typedef struct {
        int         r;
        int         c;
        logic [3:0] exp_code;
        logic [3:0] exp_row;
        logic [3:0] next_row;
    } vec_t;

    vec_t vecs[4];

    matrix_key_scanner #(
        .NROWS     (4),
        .NCOLS     (4),
        .SCAN_DIV  (8),
        .SETTLE    (3),
        .DB_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .multi_key (multi_key),
        .overrun   (overrun)
    );

    always #HALF clk = ~clk;

    // A pressed switch pulls its column low only while its row is driven.
    always_comb begin
        col = '1;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                if (pressed[r*NC+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && key_valid && !prev_valid) valid_rises++;
        if (overrun) ovr_cnt++;
        if (multi_key) multi_cnt++;
        prev_valid = key_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held(input logic lvl, input int bound, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            n++;
            if (key_held == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_row(input logic [3:0] pat, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (row == pat) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #(2 * HALF * 20000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         ok;
        int         n;
        int         rise0;
        int         ovr0;
        int         multi0;
        int         changes;
        bit         hseen;
        logic [3:0] one;
        logic [3:0] last_row;
        logic [3:0] exp_row;

        one = 4'b0001;
        vecs[0] = '{2, 1, 4'd9,  4'b1011, 4'b0111};
        vecs[1] = '{0, 0, 4'd0,  4'b1110, 4'b1101};
        vecs[2] = '{3, 3, 4'd15, 4'b0111, 4'b1110};
        vecs[3] = '{1, 2, 4'd6,  4'b1101, 4'b1011};

        // Reset and idle scan
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_row", 32'(row), 32'(4'b1110));
        check("reset_outputs", 32'({key_valid, key_held, multi_key, overrun, key_code}), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            exp_row = ~(one << ((k / 8) % 4));
            check("idle_row_seq", 32'(row), 32'(exp_row));
            check("idle_flags", 32'({key_valid, key_held, multi_key}), 32'd0);
            @(negedge clk);
        end

        // Single-key presses from the vector table
        key_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rise0 = valid_rises;
            pressed[vecs[i].r*NC+vecs[i].c] = 1'b1;
            exp_q.push_back(int'(vecs[i].exp_code));
            wait_valid(200, ok);
            check("press_timeout", 32'(ok), 32'd1);
            check("event_code", 32'(key_code), 32'(exp_q.pop_front()));
            check("held_on_press", 32'(key_held), 32'd1);
            check("row_frozen", 32'(row), 32'(vecs[i].exp_row));
            repeat (5) @(negedge clk);
            check("row_still_frozen", 32'(row), 32'(vecs[i].exp_row));
            check("valid_stable", 32'(key_valid), 32'd1);
            key_ready = 1'b1;
            @(negedge clk);
            key_ready = 1'b0;
            check("valid_after_ready", 32'(key_valid), 32'd0);
            pressed = '0;
            wait_held(1'b0, 100, ok, n);
            check("release_timeout", 32'(ok), 32'd1);
            check("release_latency", 32'((n >= 17) && (n <= 20)), 32'd1);
            check("row_after_release", 32'(row), 32'(vecs[i].next_row));
            check("one_event", 32'(valid_rises - rise0), 32'd1);
        end
        check("no_spurious_overrun", 32'(ovr_cnt), 32'd0);

        // Bounce on key 0 during row 0
        wait_row(4'b1110, 64, ok);
        check("bounce_row0_timeout", 32'(ok), 32'd1);
        rise0 = valid_rises;
        hseen = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (t % 5 == 0) pressed[0] = ~pressed[0];
            @(negedge clk);
            if (key_held) hseen = 1'b1;
        end
        pressed = '0;
        check("bounce_no_event", 32'(valid_rises - rise0), 32'd0);
        check("bounce_no_held", 32'(hseen), 32'd0);
        changes  = 0;
        last_row = row;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (row != last_row) changes++;
            last_row = row;
        end
        check("bounce_scan_resumes", 32'(changes >= 4), 32'd1);

        // Two keys in row 1
        rise0   = valid_rises;
        multi0  = multi_cnt;
        changes = 0;
        pressed[4] = 1'b1;
        pressed[5] = 1'b1;
        last_row = row;
        for (int t = 0; t < 48; t++) begin
            @(negedge clk);
            if (row != last_row) changes++;
            last_row = row;
        end
        check("multi_seen", 32'(multi_cnt > multi0), 32'd1);
        check("multi_rotates", 32'(changes >= 5), 32'd1);
        check("multi_no_event", 32'(valid_rises - rise0), 32'd0);
        pressed = '0;
        repeat (12) @(negedge clk);
        multi0 = multi_cnt;
        repeat (24) @(negedge clk);
        check("multi_cleared", 32'(multi_cnt - multi0), 32'd0);

        // Overrun: key 0 left pending, then key 5
        pressed[0] = 1'b1;
        exp_q.push_back(0);
        wait_valid(200, ok);
        check("ovr_first_timeout", 32'(ok), 32'd1);
        check("ovr_first_code", 32'(key_code), 32'(exp_q.pop_front()));
        pressed = '0;
        wait_held(1'b0, 100, ok, n);
        check("ovr_release_timeout", 32'(ok), 32'd1);
        ovr0 = ovr_cnt;
        pressed[5] = 1'b1;
        wait_held(1'b1, 200, ok, n);
        check("ovr_second_timeout", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        check("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        check("ovr_code_kept", 32'(key_code), 32'd0);
        check("ovr_valid_kept", 32'(key_valid), 32'd1);

        // Asynchronous reset while HELD with an event pending
        #50;
        rst_n = 1'b0;
        #1;
        check("async_reset_row", 32'(row), 32'(4'b1110));
        check("async_reset_outputs", 32'({key_valid, key_held, multi_key, overrun, key_code}), 32'd0);
        repeat (2) @(negedge clk);
        pressed = '0;
        rst_n   = 1'b1;
        check("post_reset_row", 32'(row), 32'(4'b1110));
        repeat (4) @(negedge clk);
        check("post_reset_quiet", 32'({key_valid, key_held}), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
